// File: rtl/serial_subtractor_if.sv
// Launch/collect handshake between a controller and the bit-serial subtractor.
// The controller drives the operands and start; the subtractor returns status and result.
interface serial_subtractor_if #(
  parameter int NUM_BITS = 4
);
  logic                start;
  logic [NUM_BITS-1:0] a;
  logic [NUM_BITS-1:0] b;
  logic                borrow_in;
  logic                busy;
  logic                done;
  logic [NUM_BITS-1:0] diff;
  logic                underflow;

  modport master (
    output start,
    output a,
    output b,
    output borrow_in,
    input  busy,
    input  done,
    input  diff,
    input  underflow
  );

  modport slave (
    input  start,
    input  a,
    input  b,
    input  borrow_in,
    output busy,
    output done,
    output diff,
    output underflow
  );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: one full-subtractor cell plus a registered borrow,
// producing (a - b - borrow_in) mod 2^NUM_BITS and the final borrow as underflow.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | waiting for start; operands are captured on the accepting edge
// SUB     | one bit per clock, LSB first; busy is high
// DONE    | one-cycle done pulse; diff/underflow already hold the result
module serial_subtractor #(
  parameter int NUM_BITS = 4
) (
  input logic           clk,
  input logic           rst,
  serial_subtractor_if.slave sub_if
);

  localparam int CNT_W = (NUM_BITS > 1) ? $clog2(NUM_BITS) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_BITS - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SUB  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]          state;
  logic [NUM_BITS-1:0] a_sh;
  logic [NUM_BITS-1:0] b_sh;
  logic [NUM_BITS-1:0] res_sh;
  logic [NUM_BITS-1:0] diff_q;
  logic                br;
  logic                uf_q;
  logic [CNT_W-1:0]    cnt;

  logic                a0;
  logic                b0;
  logic                d_bit;
  logic                br_next;
  logic                last_bit;
  logic [NUM_BITS-1:0] res_next;

  assign a0       = a_sh[0];
  assign b0       = b_sh[0];
  assign d_bit    = a0 ^ b0 ^ br;
  assign br_next  = (~a0 & b0) | (~(a0 ^ b0) & br);
  assign last_bit = (cnt == LAST_CNT);

  // Difference bits enter at the MSB so the LSB-first stream ends up aligned.
  assign res_next = {d_bit, res_sh[NUM_BITS-1:1]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      a_sh   <= '0;
      b_sh   <= '0;
      res_sh <= '0;
      diff_q <= '0;
      br     <= 1'b0;
      uf_q   <= 1'b0;
      cnt    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (sub_if.start) begin
            a_sh   <= sub_if.a;
            b_sh   <= sub_if.b;
            br     <= sub_if.borrow_in;
            res_sh <= '0;
            cnt    <= '0;
            state  <= ST_SUB;
          end
        end

        ST_SUB: begin
          a_sh   <= a_sh >> 1;
          b_sh   <= b_sh >> 1;
          res_sh <= res_next;
          br     <= br_next;
          cnt    <= cnt + CNT_ONE;
          // Outputs are published only here, so they hold through the next operation.
          if (last_bit) begin
            diff_q <= res_next;
            uf_q   <= br_next;
            state  <= ST_DONE;
          end
        end

        ST_DONE: begin
          state <= ST_IDLE;
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign sub_if.busy      = (state == ST_SUB);
  assign sub_if.done      = (state == ST_DONE);
  assign sub_if.diff      = diff_q;
  assign sub_if.underflow = uf_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Randomized and directed checks of serial_subtractor at NUM_BITS=4 and NUM_BITS=8
// against a plain-arithmetic reference model.
module tb_serial_subtractor;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  serial_subtractor_if #(.NUM_BITS(4)) if4();
  serial_subtractor_if #(.NUM_BITS(8)) if8();

  serial_subtractor #(.NUM_BITS(4)) dut4 (
    .clk    (clk),
    .rst    (rst),
    .sub_if (if4.slave)
  );

  serial_subtractor #(.NUM_BITS(8)) dut8 (
    .clk    (clk),
    .rst    (rst),
    .sub_if (if8.slave)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model: plain integer arithmetic.
  function automatic logic [31:0] ref_diff(input int w, input longint av, input longint bv,
                                           input longint bi);
    longint mask;
    mask = (longint'(1) << w) - 1;
    return 32'((av - bv - bi) & mask);
  endfunction

  function automatic logic [31:0] ref_uf(input longint av, input longint bv, input longint bi);
    return (av < bv + bi) ? 32'd1 : 32'd0;
  endfunction

  task automatic drive(input int w, input logic s, input logic [31:0] av, input logic [31:0] bv,
                       input logic bi);
    if (w == 8) begin
      if8.start = s; if8.a = av[7:0]; if8.b = bv[7:0]; if8.borrow_in = bi;
    end else begin
      if4.start = s; if4.a = av[3:0]; if4.b = bv[3:0]; if4.borrow_in = bi;
    end
  endtask

  function automatic logic get_busy(input int w);
    return (w == 8) ? if8.busy : if4.busy;
  endfunction

  function automatic logic get_done(input int w);
    return (w == 8) ? if8.done : if4.done;
  endfunction

  function automatic logic [31:0] get_diff(input int w);
    return (w == 8) ? 32'(if8.diff) : 32'(if4.diff);
  endfunction

  function automatic logic [31:0] get_uf(input int w);
    return (w == 8) ? 32'(if8.underflow) : 32'(if4.underflow);
  endfunction

  // One operation; with disturb set, a second start with new operands is raised mid-flight.
  task automatic run_op(input int w, input logic [31:0] av, input logic [31:0] bv,
                        input logic bi, input bit disturb, input string tag);
    int lat;
    int bcnt;
    lat  = 0;
    bcnt = 0;
    @(negedge clk);
    drive(w, 1'b1, av, bv, bi);
    @(posedge clk);
    @(negedge clk);
    drive(w, 1'b0, av, bv, bi);
    while (!get_done(w) && lat < 40) begin
      if (get_busy(w)) bcnt++;
      lat++;
      @(negedge clk);
      if (disturb && lat == 1) drive(w, 1'b1, 32'd1, 32'd1, 1'b0);
      if (disturb && lat == 3) drive(w, 1'b0, 32'd1, 32'd1, 1'b0);
    end
    check_val({tag, "_latency"}, 32'(lat), 32'(w));
    check_val({tag, "_busy_cycles"}, 32'(bcnt), 32'(w));
    check_val({tag, "_diff"}, get_diff(w), ref_diff(w, longint'(av), longint'(bv), longint'(bi)));
    check_val({tag, "_underflow"}, get_uf(w), ref_uf(longint'(av), longint'(bv), longint'(bi)));
    @(negedge clk);
    check_val({tag, "_done_width"}, 32'(get_done(w)), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_done;
    int last;
    int stable_bad;
    logic [31:0] ra, rb;
    logic        rbi;

    rst = 1'b1;
    drive(4, 1'b0, 32'd0, 32'd0, 1'b0);
    drive(8, 1'b0, 32'd0, 32'd0, 1'b0);
    repeat (3) @(negedge clk);
    check_val("rst_busy", 32'(if4.busy), 32'd0);
    check_val("rst_done", 32'(if4.done), 32'd0);
    check_val("rst_diff", 32'(if4.diff), 32'd0);
    check_val("rst_uf", 32'(if4.underflow), 32'd0);
    check_val("rst_diff8", 32'(if8.diff), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    run_op(4, 32'd9, 32'd3, 1'b0, 1'b0, "s9m3");
    run_op(4, 32'd3, 32'd9, 1'b0, 1'b0, "s3m9");
    run_op(4, 32'd0, 32'd0, 1'b1, 1'b0, "s0m0b1");
    run_op(4, 32'd15, 32'd15, 1'b0, 1'b0, "s15m15");

    // Mid-flight start with changed operands is ignored.
    run_op(4, 32'd12, 32'd5, 1'b0, 1'b1, "ignored_start");
    n_done = 0;
    repeat (10) begin
      @(negedge clk);
      if (if4.done) n_done++;
    end
    check_val("ignored_no_extra_done", 32'(n_done), 32'd0);
    check_val("ignored_hold_diff", 32'(if4.diff), 32'd7);
    check_val("ignored_hold_uf", 32'(if4.underflow), 32'd0);

    // Synchronous reset during the second SUB cycle abandons the operation.
    @(negedge clk);
    drive(4, 1'b1, 32'd9, 32'd3, 1'b0);
    @(posedge clk);
    @(negedge clk);
    drive(4, 1'b0, 32'd9, 32'd3, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_val("midrst_busy", 32'(if4.busy), 32'd0);
    check_val("midrst_done", 32'(if4.done), 32'd0);
    check_val("midrst_diff", 32'(if4.diff), 32'd0);
    check_val("midrst_uf", 32'(if4.underflow), 32'd0);
    n_done = 0;
    repeat (10) begin
      @(negedge clk);
      if (if4.done) n_done++;
    end
    check_val("midrst_no_done", 32'(n_done), 32'd0);
    run_op(4, 32'd5, 32'd2, 1'b0, 1'b0, "after_rst");

    // Back-to-back with start held high.
    @(negedge clk);
    drive(4, 1'b1, 32'd8, 32'd1, 1'b0);
    n_done     = 0;
    last       = -1;
    stable_bad = 0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      @(negedge clk);
      if (if4.done) begin
        if (last >= 0) check_val("b2b_period", 32'(cyc - last), 32'd6);
        check_val("b2b_diff", 32'(if4.diff), 32'd7);
        check_val("b2b_uf", 32'(if4.underflow), 32'd0);
        last = cyc;
        n_done++;
      end
      if (last >= 0 && if4.diff !== 4'd7) stable_bad++;
    end
    check_val("b2b_count", 32'(n_done), 32'd6);
    check_val("b2b_diff_stable", 32'(stable_bad), 32'd0);
    drive(4, 1'b0, 32'd8, 32'd1, 1'b0);
    for (int i = 0; i < 20 && (if4.busy || if4.done); i++) @(negedge clk);
    @(negedge clk);

    // Exhaustive sweep at NUM_BITS=4.
    for (int ai = 0; ai < 16; ai++)
      for (int bi = 0; bi < 16; bi++)
        for (int ci = 0; ci < 2; ci++)
          run_op(4, 32'(ai), 32'(bi), ci[0], 1'b0, "sweep4");

    // Corners and random sweep at NUM_BITS=8.
    run_op(8, 32'd0, 32'd255, 1'b1, 1'b0, "c8_min");
    run_op(8, 32'd255, 32'd0, 1'b0, 1'b0, "c8_max");
    run_op(8, 32'd128, 32'd128, 1'b1, 1'b0, "c8_eq_b1");
    for (int i = 0; i < 250; i++) begin
      ra  = 32'($urandom_range(0, 255));
      rb  = 32'($urandom_range(0, 255));
      rbi = 1'($urandom_range(0, 1));
      run_op(8, ra, rb, rbi, 1'b0, "rand8");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
